// File: rtl/bcd_down_timer.sv
// Loadable multi-digit BCD countdown timer.
// A BCD preset counts down to zero, one step per external tick strobe, under
// an IDLE/RUN/EXPIRED run-control FSM. Expiry raises a one-cycle done pulse
// and a sticky expired flag. Every output comes straight from a flop.
module bcd_down_timer #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  tick,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  expired,
    output logic                  done,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic           running_q, expired_q, done_q, done_d, load_err_q, load_err_d;

    logic [W-1:0]   ld_clamp;
    logic           ld_bad;
    logic [W-1:0]   cnt_dec;
    logic           cnt_zero, cnt_one;

    // Clamp each preset digit above 9 down to 9 and flag the bad load.
    always_comb begin
        ld_clamp = load_val;
        ld_bad   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                ld_clamp[4*i +: 4] = 4'd9;
                ld_bad             = 1'b1;
            end
        end
    end

    // BCD decrement: a 0 digit wraps to 9 and passes the borrow up the chain.
    always_comb begin
        logic borrow;
        cnt_dec = count_q;
        borrow  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    cnt_dec[4*i +: 4] = 4'd9;
                end else begin
                    cnt_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    assign cnt_zero = (count_q == '0);
    assign cnt_one  = (count_q == W'(1));

    // Next-state logic; priority is load > start > tick (reset is in the flop).
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            count_d    = ld_clamp;
            state_d    = IDLE;
            load_err_d = ld_bad;
        end else begin
            case (state_q)
                IDLE: begin
                    // No decrement on the start edge, even with tick high.
                    if (start) begin
                        if (cnt_zero) begin
                            state_d = EXPIRED;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    // The zero guard keeps the count from ever wrapping below 0.
                    if (tick && !pause && !cnt_zero) begin
                        count_d = cnt_dec;
                        if (cnt_one) begin
                            state_d = EXPIRED;
                            done_d  = 1'b1;
                        end
                    end
                end
                EXPIRED: ;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and registered outputs; running/expired follow the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            running_q  <= 1'b0;
            expired_q  <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            running_q  <= (state_d == RUN);
            expired_q  <= (state_d == EXPIRED);
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign running  = running_q;
    assign expired  = expired_q;
    assign done     = done_q;
    assign load_err = load_err_q;

endmodule
